// File: rtl/wb_arb2_pkg.sv
// Shared constants for the two-master Wishbone arbiter: grant state encoding and timeout width.
package wb_arb2_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'b00;
   localparam state_t GNT0 = 2'b01;
   localparam state_t GNT1 = 2'b10;

   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/wb_arb2_rr.sv
// Round-robin grant FSM: owns the state and last-granted registers and computes the next grant.
module wb_arb2_rr
   import wb_arb2_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   m0_cyc,
   input  logic   m1_cyc,
   output state_t state,
   output state_t state_next
);

   state_t state_q, state_d;
   // last_q = 1 means m1 owned the bus most recently, so m0 wins the next tie
   logic   last_q, last_d;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc && m1_cyc) state_d = last_q ? GNT0 : GNT1;
            else if (m0_cyc)      state_d = GNT0;
            else if (m1_cyc)      state_d = GNT1;
         end
         GNT0: begin
            if (!m0_cyc) begin
               last_d  = 1'b0;
               state_d = m1_cyc ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc) begin
               last_d  = 1'b1;
               state_d = m0_cyc ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign state      = state_q;
   assign state_next = state_d;

endmodule

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter in front of a single shared slave.
// Optional stall timeout with error abort is enabled by defining WB_ARB2_TIMEOUT_EN.
module wb_arb2
   import wb_arb2_pkg::*;
#(
   parameter int unsigned dat_width      = 32,
   parameter int unsigned adr_width      = 32,
   parameter int unsigned timeout_cycles = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,

   input  logic                   m0_cyc_i,
   input  logic                   m0_stb_i,
   input  logic                   m0_we_i,
   input  logic [adr_width-1:0]   m0_adr_i,
   input  logic [dat_width-1:0]   m0_dat_i,
   input  logic [dat_width/8-1:0] m0_sel_i,
   output logic [dat_width-1:0]   m0_dat_o,
   output logic                   m0_ack_o,
   output logic                   m0_err_o,

   input  logic                   m1_cyc_i,
   input  logic                   m1_stb_i,
   input  logic                   m1_we_i,
   input  logic [adr_width-1:0]   m1_adr_i,
   input  logic [dat_width-1:0]   m1_dat_i,
   input  logic [dat_width/8-1:0] m1_sel_i,
   output logic [dat_width-1:0]   m1_dat_o,
   output logic                   m1_ack_o,
   output logic                   m1_err_o,

   output logic                   s_cyc_o,
   output logic                   s_stb_o,
   output logic                   s_we_o,
   output logic [adr_width-1:0]   s_adr_o,
   output logic [dat_width-1:0]   s_dat_o,
   output logic [dat_width/8-1:0] s_sel_o,
   input  logic [dat_width-1:0]   s_dat_i,
   input  logic                   s_ack_i,

   output logic [1:0]             grant_o
);

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(timeout_cycles);

   state_t state, state_next;
   logic   gnt0, gnt1, stb_raw;

   wb_arb2_rr u_rr (
      .clk        (clk),
      .rst_n      (rst_n),
      .m0_cyc     (m0_cyc_i),
      .m1_cyc     (m1_cyc_i),
      .state      (state),
      .state_next (state_next)
   );

   assign gnt0    = (state == GNT0);
   assign gnt1    = (state == GNT1);
   assign grant_o = {gnt1, gnt0};

   // Idle routes master 0 so the slave sees stable address/data
   assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
   assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
   assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
   assign s_we_o  = gnt1 ? m1_we_i  : m0_we_i;
   assign s_cyc_o = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
   assign stb_raw = (gnt0 & m0_cyc_i & m0_stb_i) | (gnt1 & m1_cyc_i & m1_stb_i);

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   // Gating with cyc drops late acks that arrive after the owner released
   assign m0_ack_o = gnt0 & m0_cyc_i & s_ack_i;
   assign m1_ack_o = gnt1 & m1_cyc_i & s_ack_i;

`ifdef WB_ARB2_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             abort;

   // Abort only without an ack in the same cycle, so ack and err never coincide
   assign abort = stb_raw & ~s_ack_i & (cnt_q == TO_LIM);

   always_comb begin
      cnt_d = cnt_q;
      if (state == IDLE || state_next != state || s_ack_i || abort) cnt_d = '0;
      else if (stb_raw)                                             cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign s_stb_o  = stb_raw & ~abort;
   assign m0_err_o = gnt0 & abort;
   assign m1_err_o = gnt1 & abort;
`else
   logic unused_cfg;

   assign unused_cfg = ^{state_next, TO_LIM};
   assign s_stb_o    = stb_raw;
   assign m0_err_o   = 1'b0;
   assign m1_err_o   = 1'b0;
`endif

endmodule
